// File: rtl/cpu_sequencer_if.sv
// Bundle of the sequencer's start/step controls, instruction fetch path and
// the register-file / ALU / data-memory control lines it drives.
interface cpu_sequencer_if;
  logic       go;
  logic       step_mode;
  logic [7:0] instruction;
  logic [7:0] imem_addr;
  logic [1:0] rs_addr;
  logic [1:0] rt_addr;
  logic       reg_we;
  logic [1:0] reg_waddr;
  logic       alu_b_sel;
  logic [7:0] imm_out;
  logic       wb_sel;
  logic       dmem_we;
  logic       busy;
  logic       halted;
  logic [7:0] instr_count;

  // Sequencer side: consumes go/step/instruction, drives all control lines.
  modport master (
    input  go, step_mode, instruction,
    output imem_addr, rs_addr, rt_addr, reg_we, reg_waddr, alu_b_sel,
           imm_out, wb_sel, dmem_we, busy, halted, instr_count
  );

  // Environment side: supplies go/step/instruction, observes control lines.
  modport slave (
    output go, step_mode, instruction,
    input  imem_addr, rs_addr, rt_addr, reg_we, reg_waddr, alu_b_sel,
           imm_out, wb_sel, dmem_we, busy, halted, instr_count
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multicycle control unit for the 8-bit, 4-register processor. Holds PC and
// IR, walks FETCH/DECODE/EXEC/MEM/WB per instruction and retires into FETCH
// (free-run) or IDLE (single-step). HALT is sticky until clear.
module cpu_sequencer #(
  parameter int         IMEM_DEPTH = 32,
  parameter logic [7:0] HALT_CODE  = 8'hC3
) (
  input  logic            clk,
  input  logic            clear,
  cpu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_JUMP  = 2'b11;

  // One bit wider than pc so the full 0..255 pc range compares correctly.
  localparam logic [8:0] IMEM_LIMIT = 9'(IMEM_DEPTH);

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] cnt_q, cnt_d;
  logic       go_q;

  logic       go_rise;
  logic [1:0] opcode;
  logic [7:0] jump_off;
  logic       retire;
  logic       reg_we_c;
  logic       dmem_we_c;

  assign go_rise  = bus.go & ~go_q;
  assign opcode   = ir_q[7:6];
  assign jump_off = {{2{ir_q[5]}}, ir_q[5:0]};

  // State, PC, IR, retire counter and go edge-detect register; clear wins.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
      pc_q    <= 8'd0;
      ir_q    <= 8'd0;
      cnt_q   <= 8'd0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      go_q    <= bus.go;
    end
  end

  // Next-state, PC/IR updates and one-cycle write strobes.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    retire    = 1'b0;
    reg_we_c  = 1'b0;
    dmem_we_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go_rise) state_d = S_FETCH;
      end
      S_FETCH: begin
        if ({1'b0, pc_q} >= IMEM_LIMIT) begin
          state_d = S_HALT;
        end else begin
          ir_d    = bus.instruction;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_q == HALT_CODE) begin
          state_d = S_HALT;
        end else begin
          pc_d    = pc_q + 8'd1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_ADD:   state_d = S_WB;
          OP_LOAD,
          OP_STORE: state_d = S_MEM;
          default: begin
            // pc already points past the jump, so only the offset is added.
            pc_d   = pc_q + jump_off;
            retire = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (opcode == OP_STORE) begin
          dmem_we_c = 1'b1;
          retire    = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_we_c = 1'b1;
        retire   = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (retire) begin
      cnt_d   = cnt_q + 8'd1;
      state_d = bus.step_mode ? S_IDLE : S_FETCH;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.rs_addr     = ir_q[5:4];
  assign bus.rt_addr     = ir_q[3:2];
  assign bus.reg_we      = reg_we_c;
  assign bus.reg_waddr   = (opcode == OP_LOAD) ? ir_q[3:2] : ir_q[1:0];
  assign bus.alu_b_sel   = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign bus.imm_out     = {{6{ir_q[1]}}, ir_q[1:0]};
  assign bus.wb_sel      = (opcode == OP_LOAD);
  assign bus.dmem_we     = dmem_we_c;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.halted      = (state_q == S_HALT);
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: reset, ADD/LOAD/STORE/JUMP sequencing,
// count wrap, single-step behaviour and running off the end of memory.
module tb_cpu_sequencer;

  logic clk;
  logic clear;
  logic [7:0] imem [32];
  int n_cmp;
  int n_bad;

  cpu_sequencer_if bus();

  cpu_sequencer #(.IMEM_DEPTH(32), .HALT_CODE(8'hC3)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  assign bus.instruction = (bus.imem_addr < 8'd32) ? imem[bus.imem_addr[4:0]] : 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_clear();
    bus.go = 1'b0;
    clear  = 1'b1;
    tick();
    tick();
    clear  = 1'b0;
  endtask

  task automatic go_pulse();
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 32; i++) imem[i] = v;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.go = 1'b0;
    bus.step_mode = 1'b0;
    fill(8'hC3);

    // Power-on reset
    do_clear();
    chk("rst_imem_addr", bus.imem_addr, 8'h00);
    chk("rst_rs", 8'(bus.rs_addr), 8'h0);
    chk("rst_rt", 8'(bus.rt_addr), 8'h0);
    chk("rst_reg_we", 8'(bus.reg_we), 8'h0);
    chk("rst_waddr", 8'(bus.reg_waddr), 8'h0);
    chk("rst_alu_b_sel", 8'(bus.alu_b_sel), 8'h0);
    chk("rst_imm", bus.imm_out, 8'h00);
    chk("rst_wb_sel", 8'(bus.wb_sel), 8'h0);
    chk("rst_dmem_we", 8'(bus.dmem_we), 8'h0);
    chk("rst_busy", 8'(bus.busy), 8'h0);
    chk("rst_halted", 8'(bus.halted), 8'h0);
    chk("rst_count", bus.instr_count, 8'h00);

    // Clear held two cycles in the middle of a LOAD
    imem[0] = 8'h49;
    go_pulse();
    tick();
    tick();
    tick();
    chk("midload_in_mem", 8'(bus.busy), 8'h1);
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    chk("midload_busy", 8'(bus.busy), 8'h0);
    chk("midload_pc", bus.imem_addr, 8'h00);
    chk("midload_count", bus.instr_count, 8'h00);
    chk("midload_reg_we", 8'(bus.reg_we), 8'h0);
    chk("midload_dmem_we", 8'(bus.dmem_we), 8'h0);
    chk("midload_halted", 8'(bus.halted), 8'h0);
    chk("midload_alu_b_sel", 8'(bus.alu_b_sel), 8'h0);
    tick();
    chk("midload_no_wb", 8'(bus.reg_we), 8'h0);

    // ADD r3 <- r1 + r2 followed by HALT, free-run
    fill(8'hC3);
    imem[0] = 8'h1B;
    do_clear();
    go_pulse();
    chk("add_fetch_busy", 8'(bus.busy), 8'h1);
    chk("add_fetch_pc", bus.imem_addr, 8'h00);
    tick();
    chk("add_dec_rs", 8'(bus.rs_addr), 8'h1);
    chk("add_dec_rt", 8'(bus.rt_addr), 8'h2);
    tick();
    chk("add_exec_pc", bus.imem_addr, 8'h01);
    chk("add_exec_reg_we", 8'(bus.reg_we), 8'h0);
    chk("add_exec_alu_b_sel", 8'(bus.alu_b_sel), 8'h0);
    tick();
    chk("add_wb_reg_we", 8'(bus.reg_we), 8'h1);
    chk("add_wb_waddr", 8'(bus.reg_waddr), 8'h3);
    chk("add_wb_sel", 8'(bus.wb_sel), 8'h0);
    chk("add_wb_count", bus.instr_count, 8'h00);
    tick();
    chk("add_after_reg_we", 8'(bus.reg_we), 8'h0);
    chk("add_after_count", bus.instr_count, 8'h01);
    tick();
    chk("halt_dec_halted", 8'(bus.halted), 8'h0);
    tick();
    chk("halt_halted", 8'(bus.halted), 8'h1);
    chk("halt_busy", 8'(bus.busy), 8'h0);
    chk("halt_count", bus.instr_count, 8'h01);
    chk("halt_pc", bus.imem_addr, 8'h01);
    go_pulse();
    tick();
    chk("halt_sticky", 8'(bus.halted), 8'h1);
    chk("halt_sticky_pc", bus.imem_addr, 8'h01);
    do_clear();
    chk("halt_cleared", 8'(bus.halted), 8'h0);

    // LOAD r2 <- M[r0+1] then STORE M[r2-2] <- r0
    fill(8'hC3);
    imem[0] = 8'h49;
    imem[1] = 8'hA2;
    do_clear();
    go_pulse();
    tick();
    tick();
    chk("ld_exec_alu_b_sel", 8'(bus.alu_b_sel), 8'h1);
    chk("ld_exec_imm", bus.imm_out, 8'h01);
    tick();
    chk("ld_mem_dmem_we", 8'(bus.dmem_we), 8'h0);
    chk("ld_mem_reg_we", 8'(bus.reg_we), 8'h0);
    tick();
    chk("ld_wb_reg_we", 8'(bus.reg_we), 8'h1);
    chk("ld_wb_waddr", 8'(bus.reg_waddr), 8'h2);
    chk("ld_wb_sel", 8'(bus.wb_sel), 8'h1);
    tick();
    chk("ld_done_pc", bus.imem_addr, 8'h01);
    chk("ld_done_count", bus.instr_count, 8'h01);
    chk("ld_done_reg_we", 8'(bus.reg_we), 8'h0);
    tick();
    tick();
    chk("st_exec_alu_b_sel", 8'(bus.alu_b_sel), 8'h1);
    chk("st_exec_imm", bus.imm_out, 8'hFE);
    chk("st_exec_dmem_we", 8'(bus.dmem_we), 8'h0);
    tick();
    chk("st_mem_dmem_we", 8'(bus.dmem_we), 8'h1);
    chk("st_mem_reg_we", 8'(bus.reg_we), 8'h0);
    tick();
    chk("st_done_dmem_we", 8'(bus.dmem_we), 8'h0);
    chk("st_done_reg_we", 8'(bus.reg_we), 8'h0);
    chk("st_done_count", bus.instr_count, 8'h02);
    chk("st_done_pc", bus.imem_addr, 8'h02);
    tick();
    tick();
    chk("ldst_halted", 8'(bus.halted), 8'h1);

    // JUMP +4 from pc 0 lands on a self-loop JUMP -1 at pc 5
    fill(8'hC3);
    imem[0] = 8'hC4;
    imem[5] = 8'hFF;
    do_clear();
    go_pulse();
    tick();
    tick();
    tick();
    chk("jmp_first_pc", bus.imem_addr, 8'h05);
    chk("jmp_first_count", bus.instr_count, 8'h01);
    for (int i = 0; i < 256; i++) begin
      tick();
      tick();
      tick();
      chk("jmp_loop_pc", bus.imem_addr, 8'h05);
      chk("jmp_loop_count", bus.instr_count, 8'(i + 2));
    end
    chk("jmp_busy", 8'(bus.busy), 8'h1);
    chk("jmp_reg_we", 8'(bus.reg_we), 8'h0);

    // Single-step through three ADDs
    fill(8'hC3);
    imem[0] = 8'h01;
    imem[1] = 8'h02;
    imem[2] = 8'h03;
    do_clear();
    bus.step_mode = 1'b1;
    go_pulse();
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    tick();
    tick();
    chk("step1_wb_waddr", 8'(bus.reg_waddr), 8'h1);
    chk("step1_wb_reg_we", 8'(bus.reg_we), 8'h1);
    tick();
    chk("step1_idle_busy", 8'(bus.busy), 8'h0);
    chk("step1_count", bus.instr_count, 8'h01);
    chk("step1_pc", bus.imem_addr, 8'h01);
    tick();
    tick();
    tick();
    chk("step1_stays_idle", 8'(bus.busy), 8'h0);
    chk("step1_count_hold", bus.instr_count, 8'h01);
    bus.go = 1'b1;
    tick();
    chk("step2_fetch_busy", 8'(bus.busy), 8'h1);
    tick();
    tick();
    tick();
    chk("step2_wb_waddr", 8'(bus.reg_waddr), 8'h2);
    tick();
    tick();
    tick();
    tick();
    tick();
    chk("step2_held_busy", 8'(bus.busy), 8'h0);
    chk("step2_held_count", bus.instr_count, 8'h02);
    chk("step2_held_pc", bus.imem_addr, 8'h02);
    bus.go = 1'b0;
    tick();
    go_pulse();
    tick();
    tick();
    tick();
    chk("step3_wb_waddr", 8'(bus.reg_waddr), 8'h3);
    tick();
    chk("step3_busy", 8'(bus.busy), 8'h0);
    chk("step3_count", bus.instr_count, 8'h03);
    bus.step_mode = 1'b0;

    // 32 ADDs with no HALT: runs off the end of instruction memory
    fill(8'h00);
    do_clear();
    go_pulse();
    repeat (128) tick();
    chk("end_fetch_busy", 8'(bus.busy), 8'h1);
    chk("end_fetch_pc", bus.imem_addr, 8'h20);
    chk("end_fetch_count", bus.instr_count, 8'h20);
    tick();
    chk("end_halted", 8'(bus.halted), 8'h1);
    chk("end_busy", 8'(bus.busy), 8'h0);
    chk("end_count", bus.instr_count, 8'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
